// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction ROM port, hazard/branch controls
// and the IF/ID plus debug outputs.
// The master side is the fetch stage. The slave side is the ROM,
// the hazard/branch logic and the observer.
interface if_stage_if;
  logic [3:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic [5:0]  PCout;
  logic [31:0] IFID_Instruction;
  logic [5:0]  IFID_PCNext;
  logic        IFID_Valid;
  logic        halted;
  logic [7:0]  fetch_count;

  modport master (
    output imem_addr, PCout, IFID_Instruction, IFID_PCNext, IFID_Valid,
           halted, fetch_count,
    input  imem_data, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, PCout, IFID_Instruction, IFID_PCNext, IFID_Valid,
           halted, fetch_count,
    output imem_data, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 8-bit MIPS pipeline.
// Owns the PC and drives the ROM address. Loads IF/ID each cycle and
// honours stalls and ID-resolved branches. Fetching a halt opcode
// freezes the front end until reset.
module if_stage #(
  parameter logic [5:0] RESET_PC    = 6'h00,
  parameter int         PC_STEP     = 4,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input logic    clk,
  input logic    rst,
  if_stage_if.master bus
);

  typedef enum logic {FETCH, HALT} state_t;

  localparam logic [5:0] STEP = PC_STEP[5:0];

  state_t      state;
  logic [5:0]  pc;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_pcnext;
  logic        ifid_valid;
  logic        halted_r;
  logic [7:0]  fetch_cnt;
  logic [5:0]  pc_inc;

  // PC arithmetic is 6-bit and wraps naturally (3C + 4 = 00).
  assign pc_inc = pc + STEP;

  assign bus.imem_addr        = pc[5:2];
  assign bus.PCout            = pc;
  assign bus.IFID_Instruction = ifid_instr;
  assign bus.IFID_PCNext      = ifid_pcnext;
  assign bus.IFID_Valid       = ifid_valid;
  assign bus.halted           = halted_r;
  assign bus.fetch_count      = fetch_cnt;

  // FETCH/HALT state machine. It owns the PC, IF/ID and the fetch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ifid_instr  <= 32'h0;
      ifid_pcnext <= 6'h0;
      ifid_valid  <= 1'b0;
      halted_r    <= 1'b0;
      fetch_cnt   <= 8'h0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.branch_taken) begin
            pc          <= bus.branch_target;
            ifid_instr  <= 32'h0;
            ifid_pcnext <= 6'h0;
            ifid_valid  <= 1'b0;
          end else if (bus.stall) begin
            pc <= pc;
          end else if (bus.imem_data[31:26] == HALT_OPCODE) begin
            ifid_instr  <= 32'h0;
            ifid_pcnext <= 6'h0;
            ifid_valid  <= 1'b0;
            halted_r    <= 1'b1;
            state       <= HALT;
          end else begin
            pc          <= pc_inc;
            ifid_instr  <= bus.imem_data;
            ifid_pcnext <= pc_inc;
            ifid_valid  <= 1'b1;
            if (fetch_cnt != 8'hFF) begin
              fetch_cnt <= fetch_cnt + 8'd1;
            end
          end
        end
        HALT: begin
          ifid_instr  <= 32'h0;
          ifid_pcnext <= 6'h0;
          ifid_valid  <= 1'b0;
          halted_r    <= 1'b1;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal
// expectations plus randomized stimulus checked against a behavioural model.
module tb_if_stage;

  logic clk;
  logic rst;
  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rom [16];
  int total = 0;
  int bad   = 0;

  int          m_pc     = 0;
  logic [31:0] m_instr  = 32'h0;
  int          m_pcnext = 0;
  bit          m_valid  = 1'b0;
  bit          m_halted = 1'b0;
  int          m_count  = 0;

  // Combinational ROM, indexed by the address the DUT presents.
  assign bus.imem_data = rom[bus.imem_addr];

  // Free-running clock: posedges at 5, 15, ...; negedges at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. PC is a plain integer stepped by 4 modulo 64.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 0; m_instr <= 32'h0; m_pcnext <= 0;
      m_valid <= 1'b0; m_halted <= 1'b0; m_count <= 0;
    end else if (m_halted) begin
      m_instr <= 32'h0; m_pcnext <= 0; m_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      m_pc <= int'(bus.branch_target);
      m_instr <= 32'h0; m_pcnext <= 0; m_valid <= 1'b0;
    end else if (bus.stall) begin
      m_pc <= m_pc;
    end else if (rom[m_pc / 4][31:26] == 6'h3F) begin
      m_instr <= 32'h0; m_pcnext <= 0; m_valid <= 1'b0; m_halted <= 1'b1;
    end else begin
      m_pc     <= (m_pc + 4) % 64;
      m_instr  <= rom[m_pc / 4];
      m_pcnext <= (m_pc + 4) % 64;
      m_valid  <= 1'b1;
      m_count  <= (m_count < 255) ? m_count + 1 : 255;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    checkOutput("m_pc",     {26'h0, bus.PCout},       m_pc);
    checkOutput("m_addr",   {28'h0, bus.imem_addr},   m_pc / 4);
    checkOutput("m_instr",  bus.IFID_Instruction,     m_instr);
    checkOutput("m_pcnext", {26'h0, bus.IFID_PCNext}, m_pcnext);
    checkOutput("m_valid",  {31'h0, bus.IFID_Valid},  {31'h0, m_valid});
    checkOutput("m_halted", {31'h0, bus.halted},      {31'h0, m_halted});
    checkOutput("m_count",  {24'h0, bus.fetch_count}, m_count);
  end

  // Drive one cycle of inputs and advance past the next rising edge.
  task automatic applyStimulus(input logic s, input logic b, input logic [5:0] t);
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
    @(negedge clk);
  endtask

  task automatic fillRom(input bit allow_halt);
    for (int i = 0; i < 16; i++) begin
      rom[i] = $urandom;
      if (!allow_halt && rom[i][31:26] == 6'h3F) rom[i][31:26] = 6'h01;
      if (allow_halt && ($urandom_range(0, 11) == 0)) rom[i][31:26] = 6'h3F;
    end
  endtask

  task automatic midCycleReset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_pc",    {26'h0, bus.PCout},      32'h0);
    checkOutput("rst_instr", bus.IFID_Instruction,    32'h0);
    checkOutput("rst_valid", {31'h0, bus.IFID_Valid}, 32'h0);
    checkOutput("rst_halt",  {31'h0, bus.halted},     32'h0);
    checkOutput("rst_count", {24'h0, bus.fetch_count}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 6'h0;
    fillRom(1'b0);
    rom[0] = 32'h11111111; rom[1] = 32'h22222222;
    rom[2] = 32'h33333333; rom[3] = 32'h44444444;
    rom[4] = 32'hFC000000; rom[8] = 32'h88888888;
    rst = 1'b0;
    #1;
    checkOutput("reset_pc",    {26'h0, bus.PCout},       32'h0);
    checkOutput("reset_instr", bus.IFID_Instruction,     32'h0);
    checkOutput("reset_valid", {31'h0, bus.IFID_Valid},  32'h0);
    checkOutput("reset_count", {24'h0, bus.fetch_count}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Free run.
    applyStimulus(0, 0, 0);
    checkOutput("run_pc1",     {26'h0, bus.PCout},       32'h04);
    checkOutput("run_instr1",  bus.IFID_Instruction,     32'h11111111);
    checkOutput("run_pcnext1", {26'h0, bus.IFID_PCNext}, 32'h04);
    applyStimulus(0, 0, 0);
    checkOutput("run_pc2",     {26'h0, bus.PCout},       32'h08);

    // Two-cycle stall at PC=8.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput("stall_pc",    {26'h0, bus.PCout},       32'h08);
      checkOutput("stall_instr", bus.IFID_Instruction,     32'h22222222);
      checkOutput("stall_count", {24'h0, bus.fetch_count}, 32'h2);
    end
    applyStimulus(0, 0, 0);
    checkOutput("resume_pc",    {26'h0, bus.PCout},       32'h0C);
    checkOutput("resume_instr", bus.IFID_Instruction,     32'h33333333);

    // Branch with stall at PC=0C.
    applyStimulus(1, 1, 6'h20);
    checkOutput("br_pc",    {26'h0, bus.PCout},      32'h20);
    checkOutput("br_valid", {31'h0, bus.IFID_Valid}, 32'h0);
    applyStimulus(0, 0, 0);
    checkOutput("br_target_instr", bus.IFID_Instruction, 32'h88888888);
    checkOutput("br_count", {24'h0, bus.fetch_count}, 32'h4);

    // Branch on the same edge the halt word is fetched.
    applyStimulus(0, 1, 6'h10);
    applyStimulus(0, 1, 6'h20);
    checkOutput("brhalt_pc",   {26'h0, bus.PCout},  32'h20);
    checkOutput("brhalt_halt", {31'h0, bus.halted}, 32'h0);

    // Halt at PC=10; branches and stalls ignored afterwards.
    applyStimulus(0, 1, 6'h10);
    applyStimulus(0, 0, 0);
    checkOutput("halt_flag", {31'h0, bus.halted}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], (i == 2), 6'h30);
      checkOutput("halt_pc",    {26'h0, bus.PCout},       32'h10);
      checkOutput("halt_instr", bus.IFID_Instruction,     32'h0);
      checkOutput("halt_count", {24'h0, bus.fetch_count}, 32'h4);
    end
    midCycleReset();

    // Wrap from 3C to 00.
    fillRom(1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0);
    checkOutput("wrap_pc3c", {26'h0, bus.PCout}, 32'h3C);
    applyStimulus(0, 0, 0);
    checkOutput("wrap_pc",     {26'h0, bus.PCout},       32'h00);
    checkOutput("wrap_pcnext", {26'h0, bus.IFID_PCNext}, 32'h00);
    checkOutput("wrap_instr",  bus.IFID_Instruction,     rom[15]);

    // Randomized traffic with occasional halts and resets.
    for (int blk = 0; blk < 4; blk++) begin
      fillRom(1'b1);
      for (int i = 0; i < 100; i++) begin
        applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                      6'($urandom));
      end
      midCycleReset();
    end

    // Saturation: 300 uninterrupted fetches.
    fillRom(1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0);
    checkOutput("sat_count", {24'h0, bus.fetch_count}, 32'hFF);
    checkOutput("sat_pc",    {26'h0, bus.PCout},       32'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
